// File: rtl/l_port_alloc_if.sv
// Handshake bundle between the L-port rr processor / input ports / L sink and the
// L-port allocation controller.
interface l_port_alloc_if #(
  parameter int unsigned CNT_W = 3
);
  logic             rrp_grant_n_i;
  logic             rrp_grant_s_i;
  logic             rrp_grant_w_i;
  logic             rrp_grant_e_i;
  logic [2:0]       rrp_grant_to_cs_i;
  logic             n_flit_valid_i;
  logic             s_flit_valid_i;
  logic             w_flit_valid_i;
  logic             e_flit_valid_i;
  logic             n_flit_tail_i;
  logic             s_flit_tail_i;
  logic             w_flit_tail_i;
  logic             e_flit_tail_i;
  logic             downstream_credit_ret_i;
  logic             ctrl_change_order_o;
  logic             ctrl_downstream_credit_o;
  logic [2:0]       ctrl_cs_sel_o;
  logic             ctrl_grant_n_o;
  logic             ctrl_grant_s_o;
  logic             ctrl_grant_w_o;
  logic             ctrl_grant_e_o;
  logic             ctrl_flit_fwd_o;
  logic [CNT_W-1:0] ctrl_credit_cnt_o;
  logic             ctrl_credit_err_o;

  modport master (
    output rrp_grant_n_i, rrp_grant_s_i, rrp_grant_w_i, rrp_grant_e_i, rrp_grant_to_cs_i,
    output n_flit_valid_i, s_flit_valid_i, w_flit_valid_i, e_flit_valid_i,
    output n_flit_tail_i, s_flit_tail_i, w_flit_tail_i, e_flit_tail_i,
    output downstream_credit_ret_i,
    input  ctrl_change_order_o, ctrl_downstream_credit_o, ctrl_cs_sel_o,
    input  ctrl_grant_n_o, ctrl_grant_s_o, ctrl_grant_w_o, ctrl_grant_e_o,
    input  ctrl_flit_fwd_o, ctrl_credit_cnt_o, ctrl_credit_err_o
  );

  modport slave (
    input  rrp_grant_n_i, rrp_grant_s_i, rrp_grant_w_i, rrp_grant_e_i, rrp_grant_to_cs_i,
    input  n_flit_valid_i, s_flit_valid_i, w_flit_valid_i, e_flit_valid_i,
    input  n_flit_tail_i, s_flit_tail_i, w_flit_tail_i, e_flit_tail_i,
    input  downstream_credit_ret_i,
    output ctrl_change_order_o, ctrl_downstream_credit_o, ctrl_cs_sel_o,
    output ctrl_grant_n_o, ctrl_grant_s_o, ctrl_grant_w_o, ctrl_grant_e_o,
    output ctrl_flit_fwd_o, ctrl_credit_cnt_o, ctrl_credit_err_o
  );
endinterface

// File: rtl/l_port_alloc_ctrl.sv
// Wormhole allocation controller for the router's local output port: locks the
// crossbar to one input from head to tail and tracks downstream credits.
module l_port_alloc_ctrl #(
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic           clk,
  input logic           reset,
  l_port_alloc_if.slave bus
);

  localparam logic [2:0]       SEL_N    = 3'b000;
  localparam logic [2:0]       SEL_S    = 3'b001;
  localparam logic [2:0]       SEL_W    = 3'b010;
  localparam logic [2:0]       SEL_E    = 3'b011;
  localparam logic [2:0]       SEL_NONE = 3'b111;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [3:0]       req;     // bit order: 0=N, 1=S, 2=W, 3=E
  logic [3:0]       valid;
  logic [3:0]       tail;
  logic [3:0]       grant;
  logic [3:0]       pick;
  logic [2:0]       pick_sel;
  logic             multi;
  logic             fwd;
  logic             fwd_tail;
  logic             ret;
  logic             change;
  logic             err;
  logic [2:0]       sel;
  logic [CNT_W-1:0] cnt;

  assign req   = {bus.rrp_grant_e_i, bus.rrp_grant_w_i, bus.rrp_grant_s_i, bus.rrp_grant_n_i};
  assign valid = {bus.e_flit_valid_i, bus.w_flit_valid_i, bus.s_flit_valid_i, bus.n_flit_valid_i};
  assign tail  = {bus.e_flit_tail_i, bus.w_flit_tail_i, bus.s_flit_tail_i, bus.n_flit_tail_i};
  assign ret   = bus.downstream_credit_ret_i;
  assign multi = (req & (req - 4'd1)) != 4'd0;

  // Fixed-priority pick; only a multi-hot grant overrides the supplied select.
  always_comb begin
    pick     = 4'b0000;
    pick_sel = bus.rrp_grant_to_cs_i;
    if (req[0]) begin
      pick = 4'b0001;
      if (multi) pick_sel = SEL_N;
    end else if (req[1]) begin
      pick = 4'b0010;
      if (multi) pick_sel = SEL_S;
    end else if (req[2]) begin
      pick = 4'b0100;
      if (multi) pick_sel = SEL_W;
    end else if (req[3]) begin
      pick = 4'b1000;
      if (multi) pick_sel = SEL_E;
    end
  end

  assign fwd      = (state == LOCKED) && ((grant & valid) != 4'd0) && (cnt != '0);
  assign fwd_tail = (grant & valid & tail) != 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= 4'b0000;
      sel    <= SEL_NONE;
      change <= 1'b0;
      cnt    <= CNT_FULL;
      err    <= 1'b0;
    end else begin
      change <= 1'b0;
      case (state)
        IDLE: begin
          // Grants are ignored while the rr order is being rotated.
          if (!change && (req != 4'd0)) begin
            grant <= pick;
            sel   <= pick_sel;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (fwd && fwd_tail) begin
            grant  <= 4'b0000;
            sel    <= SEL_NONE;
            change <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (fwd && !ret) begin
        cnt <= cnt - CNT_W'(1);
      end else if (ret && !fwd) begin
        if (cnt == CNT_FULL) err <= 1'b1;
        else                 cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ctrl_change_order_o      = change;
  assign bus.ctrl_downstream_credit_o = (cnt != '0);
  assign bus.ctrl_cs_sel_o            = sel;
  assign bus.ctrl_grant_n_o           = grant[0];
  assign bus.ctrl_grant_s_o           = grant[1];
  assign bus.ctrl_grant_w_o           = grant[2];
  assign bus.ctrl_grant_e_o           = grant[3];
  assign bus.ctrl_flit_fwd_o          = fwd;
  assign bus.ctrl_credit_cnt_o        = cnt;
  assign bus.ctrl_credit_err_o        = err;

endmodule

// File: tb/tb_l_port_alloc_ctrl.sv
// Bench for the L-port allocation controller: directed packet scenarios with a
// scoreboard of expected (source, select) pairs popped on every forwarded flit.
module tb_l_port_alloc_ctrl;

  typedef struct packed {
    logic [3:0] src_oh;
    logic [2:0] sel;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  l_port_alloc_if #(.CNT_W(3)) bus ();

  l_port_alloc_ctrl #(.CREDIT_DEPTH(4), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_grant(input logic [3:0] g, input logic [2:0] cs);
    bus.rrp_grant_n_i     = g[0];
    bus.rrp_grant_s_i     = g[1];
    bus.rrp_grant_w_i     = g[2];
    bus.rrp_grant_e_i     = g[3];
    bus.rrp_grant_to_cs_i = cs;
  endtask

  task automatic set_flit(input logic [3:0] v, input logic [3:0] t);
    bus.n_flit_valid_i = v[0];
    bus.s_flit_valid_i = v[1];
    bus.w_flit_valid_i = v[2];
    bus.e_flit_valid_i = v[3];
    bus.n_flit_tail_i  = t[0];
    bus.s_flit_tail_i  = t[1];
    bus.w_flit_tail_i  = t[2];
    bus.e_flit_tail_i  = t[3];
  endtask

  task automatic expect_flit(input logic [3:0] oh, input logic [2:0] s);
    exp_t e;
    e.src_oh = oh;
    e.sel    = s;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] grant_vec();
    return {bus.ctrl_grant_e_o, bus.ctrl_grant_w_o, bus.ctrl_grant_s_o, bus.ctrl_grant_n_o};
  endfunction

  // Generic packet from one source; sel encoding equals the source index.
  task automatic send_pkt(input int src, input int nfl);
    logic [3:0] oh;
    int         w;
    oh = 4'(1 << src);
    set_grant(oh, 3'(src));
    for (int f = 0; f < nfl; f++) begin
      set_flit(oh, (f == nfl - 1) ? oh : 4'b0000);
      expect_flit(oh, 3'(src));
      if (f == 0) begin
        step();
        set_grant(4'b0000, 3'b000);
      end
      w = 0;
      mid();
      while (bus.ctrl_flit_fwd_o !== 1'b1 && w < 20) begin
        mid();
        w++;
      end
      chk("pkt_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
      step();
    end
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("pkt_change", 32'(bus.ctrl_change_order_o), 32'd1);
    step();
  endtask

  // Scoreboard: every forwarded flit must match the oldest expectation.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (!reset && bus.ctrl_flit_fwd_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_fwd_unexpected", 32'(bus.ctrl_flit_fwd_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_grant", 32'(grant_vec()), 32'(e.src_oh));
        chk("sb_sel", 32'(bus.ctrl_cs_sel_o), 32'(e.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clk      = 1'b0;
    reset    = 1'b1;

    // T1: reset with arbitrary inputs
    set_grant(4'($urandom), 3'($urandom));
    set_flit(4'($urandom), 4'($urandom));
    bus.downstream_credit_ret_i = 1'($urandom);
    step();
    step();
    mid();
    chk("t1_sel", 32'(bus.ctrl_cs_sel_o), 32'h7);
    chk("t1_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd4);
    chk("t1_credit", 32'(bus.ctrl_downstream_credit_o), 32'd1);
    chk("t1_grant", 32'(grant_vec()), 32'd0);
    chk("t1_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    chk("t1_change", 32'(bus.ctrl_change_order_o), 32'd0);
    chk("t1_err", 32'(bus.ctrl_credit_err_o), 32'd0);
    step();
    reset = 1'b0;
    set_grant(4'b0000, 3'b111);
    set_flit(4'b0000, 4'b0000);
    bus.downstream_credit_ret_i = 1'b0;

    // T2: single-flit packet from W
    set_grant(4'b0100, 3'b010);
    set_flit(4'b0100, 4'b0100);
    expect_flit(4'b0100, 3'b010);
    mid();
    chk("t2_idle_no_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("t2_grant_w", 32'(grant_vec()), 32'h4);
    chk("t2_sel", 32'(bus.ctrl_cs_sel_o), 32'h2);
    chk("t2_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    chk("t2_cnt_pre", 32'(bus.ctrl_credit_cnt_o), 32'd4);
    step();
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("t2_change", 32'(bus.ctrl_change_order_o), 32'd1);
    chk("t2_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd3);
    chk("t2_sel_idle", 32'(bus.ctrl_cs_sel_o), 32'h7);
    chk("t2_grant_clr", 32'(grant_vec()), 32'd0);
    step();
    mid();
    chk("t2_change_1cyc", 32'(bus.ctrl_change_order_o), 32'd0);
    step();

    // Two-flit packet from E brings the count down to 1
    send_pkt(3, 2);
    mid();
    chk("e_pkt_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd1);
    step();

    // T3: credit stall on a 3-flit packet from N
    set_grant(4'b0001, 3'b000);
    set_flit(4'b0001, 4'b0000);
    expect_flit(4'b0001, 3'b000);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("t3_f1_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    step();
    expect_flit(4'b0001, 3'b000);
    mid();
    chk("t3_stall_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    chk("t3_cnt0", 32'(bus.ctrl_credit_cnt_o), 32'd0);
    chk("t3_credit_o", 32'(bus.ctrl_downstream_credit_o), 32'd0);
    chk("t3_hold_n", 32'(grant_vec()), 32'h1);
    step();
    mid();
    chk("t3_stall_fwd2", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    chk("t3_hold_sel", 32'(bus.ctrl_cs_sel_o), 32'h0);
    step();
    bus.downstream_credit_ret_i = 1'b1;
    mid();
    chk("t3_ret_cycle_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    step();
    bus.downstream_credit_ret_i = 1'b0;
    mid();
    chk("t3_f2_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    chk("t3_f2_grant", 32'(grant_vec()), 32'h1);
    chk("t3_f2_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd1);
    step();
    set_flit(4'b0001, 4'b0001);
    expect_flit(4'b0001, 3'b000);
    bus.downstream_credit_ret_i = 1'b1;
    mid();
    chk("t3_f3_stall", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    step();
    bus.downstream_credit_ret_i = 1'b0;
    mid();
    chk("t3_f3_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    step();
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("t3_change", 32'(bus.ctrl_change_order_o), 32'd1);
    chk("t3_cnt_end", 32'(bus.ctrl_credit_cnt_o), 32'd0);
    step();

    // T4: simultaneous forward and return at count 2
    bus.downstream_credit_ret_i = 1'b1;
    step();
    step();
    bus.downstream_credit_ret_i = 1'b0;
    set_grant(4'b0010, 3'b001);
    set_flit(4'b0010, 4'b0000);
    expect_flit(4'b0010, 3'b001);
    mid();
    chk("t4_cnt2", 32'(bus.ctrl_credit_cnt_o), 32'd2);
    step();
    set_grant(4'b0000, 3'b000);
    bus.downstream_credit_ret_i = 1'b1;
    mid();
    chk("t4_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    step();
    bus.downstream_credit_ret_i = 1'b0;
    set_flit(4'b0010, 4'b0010);
    expect_flit(4'b0010, 3'b001);
    mid();
    chk("t4_cnt_same", 32'(bus.ctrl_credit_cnt_o), 32'd2);
    chk("t4_err", 32'(bus.ctrl_credit_err_o), 32'd0);
    step();
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("t4_change", 32'(bus.ctrl_change_order_o), 32'd1);
    chk("t4_cnt_end", 32'(bus.ctrl_credit_cnt_o), 32'd1);
    step();

    // T5: grant arriving on the change_order cycle is suppressed
    bus.downstream_credit_ret_i = 1'b1;
    step();
    step();
    bus.downstream_credit_ret_i = 1'b0;
    set_grant(4'b0100, 3'b010);
    set_flit(4'b0100, 4'b0100);
    expect_flit(4'b0100, 3'b010);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("t5_w_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    step();
    set_grant(4'b1000, 3'b011);
    set_flit(4'b1000, 4'b1000);
    expect_flit(4'b1000, 3'b011);
    mid();
    chk("t5_change", 32'(bus.ctrl_change_order_o), 32'd1);
    step();
    mid();
    chk("t5_ignored_grant", 32'(grant_vec()), 32'd0);
    chk("t5_ignored_sel", 32'(bus.ctrl_cs_sel_o), 32'h7);
    chk("t5_ignored_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd0);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("t5_accepted", 32'(grant_vec()), 32'h8);
    chk("t5_sel", 32'(bus.ctrl_cs_sel_o), 32'h3);
    chk("t5_fwd", 32'(bus.ctrl_flit_fwd_o), 32'd1);
    step();
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("t5_change_end", 32'(bus.ctrl_change_order_o), 32'd1);
    chk("t5_cnt_end", 32'(bus.ctrl_credit_cnt_o), 32'd1);
    step();

    // T6: reset mid-packet, then overflow return at full count
    set_grant(4'b0010, 3'b001);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("t6_locked_s", 32'(grant_vec()), 32'h2);
    step();
    reset = 1'b1;
    mid();
    chk("t6_rst_grant", 32'(grant_vec()), 32'd0);
    chk("t6_rst_sel", 32'(bus.ctrl_cs_sel_o), 32'h7);
    chk("t6_rst_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd4);
    chk("t6_rst_change", 32'(bus.ctrl_change_order_o), 32'd0);
    step();
    reset = 1'b0;
    mid();
    chk("t6_no_change", 32'(bus.ctrl_change_order_o), 32'd0);
    step();
    bus.downstream_credit_ret_i = 1'b1;
    mid();
    chk("t6_err_pre", 32'(bus.ctrl_credit_err_o), 32'd0);
    step();
    bus.downstream_credit_ret_i = 1'b0;
    mid();
    chk("t6_ovf_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd4);
    chk("t6_ovf_err", 32'(bus.ctrl_credit_err_o), 32'd1);
    step();
    step();
    mid();
    chk("t6_err_sticky", 32'(bus.ctrl_credit_err_o), 32'd1);
    step();

    // Malformed multi-hot grant: N wins and sel is re-encoded
    set_grant(4'b0101, 3'b010);
    set_flit(4'b0101, 4'b0101);
    expect_flit(4'b0001, 3'b000);
    step();
    set_grant(4'b0000, 3'b000);
    mid();
    chk("mal_grant", 32'(grant_vec()), 32'h1);
    chk("mal_sel", 32'(bus.ctrl_cs_sel_o), 32'h0);
    step();
    set_flit(4'b0000, 4'b0000);
    mid();
    chk("mal_change", 32'(bus.ctrl_change_order_o), 32'd1);
    chk("mal_cnt", 32'(bus.ctrl_credit_cnt_o), 32'd3);
    chk("mal_err_sticky", 32'(bus.ctrl_credit_err_o), 32'd1);
    step();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
